seq_addsub: RTL and testbench



---
 rtl/seq_addsub.sv | 131 +++++++++++++
 tb/tb_seq_addsub.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub.sv
// Slice-serial adder/subtractor with signed/unsigned compare, valid/ready on both sides.
// Define ADDSUB_FLAGS_EN to add registered cout/ovf/zero outputs for the full-width add.
module seq_addsub #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef ADDSUB_FLAGS_EN
    ,
    output logic             cout,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int NSLICES = WIDTH / SLICE;
    localparam int CW = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICES - 1);

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_slice
            $error("seq_addsub: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    // state | meaning
    // IDLE  | waiting for operands, in_ready high
    // CALC  | one slice per edge, count 0..NSLICES-1
    // DONE  | result held on out until out_ready
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic [1:0]       op_r;
    logic             carry;
    logic [CW-1:0]    count;

    logic [31:0]      base;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] s_sl;
    logic             c_sl;
    logic [WIDTH-1:0] sum_full;
    logic             ovf_c;
    logic [WIDTH-1:0] res;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // sum_full is the partial sum with the current slice merged in; on the
    // last slice it is the complete result, so out can be loaded on that edge.
    always_comb begin
        base = 32'(count) * 32'(SLICE);
        a_sl = a_r[base +: SLICE];
        b_sl = b_r[base +: SLICE];
        {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};
        sum_full = sum_r;
        sum_full[base +: SLICE] = s_sl;
        ovf_c = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_full[WIDTH-1] != a_r[WIDTH-1]);
        res = '0;
        case (op_r)
            2'b10:   res[0] = ~c_sl;
            2'b11:   res[0] = sum_full[WIDTH-1] ^ ovf_c;
            default: res = sum_full;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
            op_r  <= '0;
            carry <= 1'b0;
            count <= '0;
            out   <= '0;
`ifdef ADDSUB_FLAGS_EN
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r   <= A;
                        b_r   <= (op != 2'b00) ? ~B : B;
                        op_r  <= op;
                        carry <= (op != 2'b00);
                        count <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    sum_r <= sum_full;
                    carry <= c_sl;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        count <= '0;
                        out   <= res;
`ifdef ADDSUB_FLAGS_EN
                        cout  <= c_sl;
                        ovf   <= ovf_c;
                        zero  <= (sum_full == '0);
`endif
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub: three instances (SLICE 8, 32, 1) run directed vectors;
// the SLICE=8 instance also covers backpressure and mid-operation reset.
module tb_seq_addsub;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] A, B;
    logic [1:0]  op;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] dout      [3];
`ifdef ADDSUB_FLAGS_EN
    logic        f_cout [3];
    logic        f_ovf  [3];
    logic        f_zero [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        seq_addsub #(.WIDTH(32), .SLICE(g == 0 ? 8 : (g == 1 ? 32 : 1))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .A         (A),
            .B         (B),
            .op        (op),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out       (dout[g])
`ifdef ADDSUB_FLAGS_EN
            ,
            .cout      (f_cout[g]),
            .ovf       (f_ovf[g]),
            .zero      (f_zero[g])
`endif
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] val;
        logic [2:0]  flg;     // {cout, ovf, zero}
        logic [31:0] edge_n;  // accept edge number
    } exp_t;
    exp_t sb [3][$];
    logic prev_ov [3];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp;
        logic [2:0]  flg;
    } vec_t;

    vec_t vecs [12] = '{
        '{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 3'b101},
        '{32'h0000_0005, 32'h0000_0007, 2'b01, 32'hFFFF_FFFE, 3'b000},
        '{32'h8000_0000, 32'h0000_0001, 2'b11, 32'h0000_0001, 3'b110},
        '{32'h8000_0000, 32'h0000_0001, 2'b10, 32'h0000_0000, 3'b110},
        '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h0000_0000, 3'b010},
        '{32'h0000_0007, 32'h0000_0007, 2'b01, 32'h0000_0000, 3'b101},
        '{32'h0000_0001, 32'h0000_0002, 2'b10, 32'h0000_0001, 3'b000},
        '{32'hFFFF_FFFF, 32'h0000_0000, 2'b11, 32'h0000_0001, 3'b100},
        '{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 3'b010},
        '{32'h00FF_00FF, 32'h0001_0001, 2'b00, 32'h0100_0100, 3'b000},
        '{32'h0000_0002, 32'h0000_0001, 2'b10, 32'h0000_0000, 3'b100},
        '{32'h0000_0000, 32'h0000_0001, 2'b01, 32'hFFFF_FFFF, 3'b000}
    };

    function automatic int nsl(int i);
        return (i == 0) ? 4 : ((i == 1) ? 1 : 32);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (out_valid[i] && !prev_ov[i]) begin
                    if (sb[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out dut%0d: out_valid with empty scoreboard, out=0x%08h", i, dout[i]);
                    end else begin
                        check($sformatf("latency dut%0d", i), 32'(cyc) - sb[i][0].edge_n, 32'(nsl(i)));
                    end
                end
                if (out_valid[i] && out_ready[i] && sb[i].size() > 0) begin
                    e = sb[i].pop_front();
                    check($sformatf("result dut%0d", i), dout[i], e.val);
`ifdef ADDSUB_FLAGS_EN
                    check($sformatf("flags dut%0d", i), {29'd0, f_cout[i], f_ovf[i], f_zero[i]}, {29'd0, e.flg});
`endif
                end
                prev_ov[i] = out_valid[i];
            end
        end
    endtask

    task automatic wait_sig(int i, bit want_ready, string name);
        int n = 0;
        while (!(want_ready ? in_ready[i] : out_valid[i]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL timeout %s dut%0d: signal stayed 0, required 1 within 200 cycles", name, i);
        end
    endtask

    task automatic issue(int i, logic [31:0] a, logic [31:0] b, logic [1:0] o,
                         logic [31:0] ex, logic [2:0] fl);
        wait_sig(i, 1'b1, "in_ready");
        A = a;
        B = b;
        op = o;
        in_valid[i] = 1'b1;
        sb[i].push_back('{val: ex, flg: fl, edge_n: 32'(cyc + 1)});
        @(negedge clk);
        in_valid[i] = 1'b0;
    endtask

    task automatic do_op(int i, vec_t v);
        issue(i, v.a, v.b, v.op, v.exp, v.flg);
        wait_sig(i, 1'b0, "out_valid");
        @(negedge clk);
        check($sformatf("in_ready_after_hs dut%0d", i), 32'(in_ready[i]), 32'd1);
        check($sformatf("out_valid_after_hs dut%0d", i), 32'(out_valid[i]), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        A = '0;
        B = '0;
        op = 2'b00;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
            prev_ov[i]   = 1'b0;
        end
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready[0]), 32'd1);
        check("reset out_valid", 32'(out_valid[0]), 32'd0);
        check("reset out", dout[0], 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++)
            for (int v = 0; v < 12; v++)
                do_op(i, vecs[v]);

        // Backpressure: result held while a competing request waits on in_valid.
        out_ready[0] = 1'b0;
        issue(0, 32'd3, 32'd4, 2'b00, 32'd7, 3'b000);
        A = 32'd9;
        B = 32'd9;
        op = 2'b00;
        in_valid[0] = 1'b1;
        wait_sig(0, 1'b0, "out_valid_bp");
        for (int k = 0; k < 6; k++) begin
            check("bp out", dout[0], 32'd7);
            check("bp out_valid", 32'(out_valid[0]), 32'd1);
            check("bp in_ready", 32'(in_ready[0]), 32'd0);
            @(negedge clk);
        end
        sb[0].push_back('{val: 32'd18, flg: 3'b000, edge_n: 32'(cyc + 2)});
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp in_ready_after_hs", 32'(in_ready[0]), 32'd1);
        check("bp out_valid_after_hs", 32'(out_valid[0]), 32'd0);
        check("bp out_kept", dout[0], 32'd7);
        @(negedge clk);
        in_valid[0] = 1'b0;
        check("bp second_accepted", 32'(in_ready[0]), 32'd0);
        wait_sig(0, 1'b0, "out_valid_bp2");
        @(negedge clk);

        // Reset at count=2 aborts the operation with nothing presented.
        wait_sig(0, 1'b1, "in_ready_rst");
        A = 32'h1234_5678;
        B = 32'h0000_0001;
        op = 2'b00;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst in_ready", 32'(in_ready[0]), 32'd1);
        check("midrst out_valid", 32'(out_valid[0]), 32'd0);
        check("midrst out", dout[0], 32'd0);
        do_op(0, '{32'd1, 32'd1, 2'b00, 32'd2, 3'b000});

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("scoreboard_drained dut%0d", i), 32'(sb[i].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
